// File: rtl/led_cube_uart_tx.sv
// led_cube_uart_tx: byte FIFO that drains into a UART over Avalon-MM, polling TRDY before each write (define LED_CUBE_UART_TX_TMT_CHECK_EN to also require TMT)
module led_cube_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter logic [4:0] STATUS_ADDR = 5'h08,
  parameter logic [4:0] TXDATA_ADDR = 5'h04
) (
  input  logic        clock_sink_clk,
  input  logic        reset_sink_reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [4:0]  avalon_master_address,
  output logic        avalon_master_read,
  input  logic [15:0] avalon_master_readdata,
  input  logic        avalon_master_readdatavalid,
  input  logic        avalon_master_waitrequest,
  output logic        avalon_master_write,
  output logic [15:0] avalon_master_writedata,
  output logic [6:0]  fifo_count,
  output logic        busy,
  output logic [7:0]  sent_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, POLL_REQ, POLL_WAIT, WRITE} state_t;
  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [6:0]    count_q;
  logic [7:0]    sent_q;
  logic          read_q, write_q;
  logic [4:0]    addr_q;
  logic [15:0]   wdata_q;
  logic          push, pop, uart_ready;
  logic          unused_rd;
`ifdef LED_CUBE_UART_TX_TMT_CHECK_EN
  assign uart_ready = avalon_master_readdata[6] & avalon_master_readdata[5];
`else
  assign uart_ready = avalon_master_readdata[6];
`endif
  assign unused_rd = ^avalon_master_readdata;
  assign tx_ready = count_q != 7'(FIFO_DEPTH);
  assign push = tx_valid & tx_ready;
  assign pop = (state_q == WRITE) & ~avalon_master_waitrequest;
  assign fifo_count = count_q;
  assign busy = state_q != IDLE;
  assign sent_count = sent_q;
  assign avalon_master_address = addr_q;
  assign avalon_master_read = read_q;
  assign avalon_master_write = write_q;
  assign avalon_master_writedata = wdata_q;
  // storage is not reset; emptiness is carried by the count
  always_ff @(posedge clock_sink_clk)
    if (push) mem_q[wr_ptr_q] <= tx_data;
  // pointers wrap naturally since depth is a power of two
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset)
    if (reset_sink_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + 7'(push) - 7'(pop);
    end
  // bus sequencer: poll status until ready, then write the FIFO head; outputs registered with the state
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset)
    if (reset_sink_reset) begin
      state_q <= IDLE;
      read_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= STATUS_ADDR;
      wdata_q <= '0;
      sent_q <= '0;
    end else
      case (state_q)
        IDLE:
          if (count_q != '0) begin
            state_q <= POLL_REQ;
            read_q <= 1'b1;
          end
        POLL_REQ:
          if (!avalon_master_waitrequest) begin
            state_q <= POLL_WAIT;
            read_q <= 1'b0;
          end
        POLL_WAIT:
          if (avalon_master_readdatavalid && uart_ready) begin
            state_q <= WRITE;
            write_q <= 1'b1;
            addr_q <= TXDATA_ADDR;
            wdata_q <= {8'h00, mem_q[rd_ptr_q]};
          end else if (avalon_master_readdatavalid) begin
            state_q <= POLL_REQ;
            read_q <= 1'b1;
          end
        WRITE:
          if (!avalon_master_waitrequest) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q <= STATUS_ADDR;
            wdata_q <= '0;
            sent_q <= sent_q + 8'd1;
          end
      endcase
endmodule

// File: tb/tb_led_cube_uart_tx.sv
// tb_led_cube_uart_tx: directed bench with a reactive Avalon slave for led_cube_uart_tx
module tb_led_cube_uart_tx;
  logic        clk = 0, rst = 1;
  logic [7:0]  tx_data = 0;
  logic        tx_valid = 0;
  logic        tx_ready;
  logic [4:0]  address;
  logic        read, write;
  logic [15:0] readdata = 0, writedata;
  logic        rdv = 0, waitreq = 0;
  logic [6:0]  fifo_count;
  logic        busy;
  logic [7:0]  sent_count;
  int n_checks = 0, n_fail = 0;
  logic [15:0] status_q [$];
  logic [15:0] wlog [$];
  logic [15:0] status_default = 16'h0040;
  int read_count = 0, wr_cycles = 0, wr_wait_cfg = 0, wr_wait_seen = 0, left = 0;
  int both_err = 0, wd_err = 0, addr_err = 0, stab_err = 0;
  bit pending = 0, in_write = 0, inject_rdv = 0;
  logic [4:0]  snap_a;
  logic [15:0] snap_d;

  led_cube_uart_tx dut (
    .clock_sink_clk(clk), .reset_sink_reset(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .avalon_master_address(address), .avalon_master_read(read),
    .avalon_master_readdata(readdata), .avalon_master_readdatavalid(rdv),
    .avalon_master_waitrequest(waitreq), .avalon_master_write(write),
    .avalon_master_writedata(writedata), .fifo_count(fifo_count),
    .busy(busy), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  // Avalon slave: answers each status read one cycle later, stalls writes wr_wait_cfg cycles, logs accepted writes
  initial forever begin
    @(negedge clk);
    if (rst) begin
      waitreq = 0; rdv = 0; pending = 0; in_write = 0;
    end else begin
      if (read && write) both_err++;
      if (!write && writedata !== 16'h0000) wd_err++;
      if (read && address !== 5'h08) addr_err++;
      if (write) wr_cycles++;
      rdv = pending || inject_rdv;
      readdata = 16'h0000;
      if (pending) readdata = status_q.size() > 0 ? status_q.pop_front() : status_default;
      else if (inject_rdv) readdata = 16'h0040;
      pending = 0;
      inject_rdv = 0;
      if (read) begin
        pending = 1;
        read_count++;
      end
      if (write) begin
        if (!in_write) begin
          in_write = 1; left = wr_wait_cfg; snap_a = address; snap_d = writedata;
          if (address !== 5'h04) addr_err++;
        end
        if (address !== snap_a || writedata !== snap_d) stab_err++;
        if (left > 0) begin
          waitreq = 1; left--; wr_wait_seen++;
        end else begin
          waitreq = 0; wlog.push_back(writedata); in_write = 0;
        end
      end else waitreq = 0;
    end
  end

  task automatic clear_logs();
    wlog.delete(); status_q.delete();
    read_count = 0; wr_cycles = 0; wr_wait_seen = 0;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (fifo_count == 0 && !busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got r=%b w=%b want 0 0", read, write); end
    n_checks++; if (writedata !== 16'h0000) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", writedata); end
    n_checks++; if (fifo_count !== 7'd0 || sent_count !== 8'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", fifo_count, sent_count); end
    n_checks++; if (busy !== 1'b0 || address !== 5'h08) begin n_fail++; $display("FAIL reset_idle: got busy=%b addr=%h want 0 08", busy, address); end
    rst = 0;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_txready: got %b want 1", tx_ready); end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    push(8'h41);
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got busy want idle"); end
    n_checks++; if (read_count != 1) begin n_fail++; $display("FAIL single_reads: got %0d want 1", read_count); end
    n_checks++; if (wlog.size() != 1 || wlog[0] !== 16'h0041) begin n_fail++; $display("FAIL single_write: got n=%0d want one write of 0041", wlog.size()); end
    n_checks++; if (sent_count !== 8'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_sent: got %0d busy=%b want 1 0", sent_count, busy); end
  endtask

  task automatic test_poll_retry();
    bit ok;
    clear_logs();
    status_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0040};
    push(8'h55);
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL retry_timeout: got busy want idle"); end
    n_checks++; if (read_count != 4) begin n_fail++; $display("FAIL retry_reads: got %0d want 4", read_count); end
    n_checks++; if (wlog.size() != 1 || wlog[0] !== 16'h0055) begin n_fail++; $display("FAIL retry_write: got n=%0d want one write of 0055", wlog.size()); end
    n_checks++; if (wd_err != 0) begin n_fail++; $display("FAIL retry_wdata_idle: got %0d nonzero cycles want 0", wd_err); end
    n_checks++; if (sent_count !== 8'd2) begin n_fail++; $display("FAIL retry_sent: got %0d want 2", sent_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    status_default = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'(i); tx_valid = 1;
      @(negedge clk);
    end
    n_checks++; if (tx_ready !== 1'b0 || fifo_count !== 7'd8) begin n_fail++; $display("FAIL full_ready: got rdy=%b cnt=%0d want 0 8", tx_ready, fifo_count); end
    tx_data = 8'hAA;
    @(negedge clk);
    tx_valid = 0;
    n_checks++; if (fifo_count !== 7'd8) begin n_fail++; $display("FAIL full_ignore: got %0d want 8", fifo_count); end
    status_default = 16'h0040;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got busy want idle"); end
    n_checks++; if (wlog.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", wlog.size()); end
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      n_checks++; if (wlog[i] !== 16'(i)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", i, wlog[i], 16'(i)); end
    end
    n_checks++; if (fifo_count !== 7'd0 || sent_count !== 8'd10) begin n_fail++; $display("FAIL b2b_counts: got %0d/%0d want 0/10", fifo_count, sent_count); end
  endtask

  task automatic test_waitrequest();
    bit ok;
    clear_logs();
    wr_wait_cfg = 5;
    push(8'h5A);
    wait_idle(ok);
    wr_wait_cfg = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wait_timeout: got busy want idle"); end
    n_checks++; if (wr_wait_seen != 5) begin n_fail++; $display("FAIL wait_cycles: got %0d want 5", wr_wait_seen); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL wait_stable: got %0d changes want 0", stab_err); end
    n_checks++; if (wlog.size() != 1 || wlog[0] !== 16'h005A) begin n_fail++; $display("FAIL wait_write: got n=%0d want one write of 005a", wlog.size()); end
    n_checks++; if (sent_count !== 8'd11) begin n_fail++; $display("FAIL wait_sent: got %0d want 11", sent_count); end
  endtask

  task automatic test_reset_mid_write();
    bit ok, seen;
    clear_logs();
    wr_wait_cfg = 50;
    for (int i = 1; i <= 3; i++) begin
      tx_data = 8'(i); tx_valid = 1;
      @(negedge clk);
    end
    tx_valid = 0;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = write;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rstw_reach: got no write want write"); end
    rst = 1;
    #1;
    n_checks++; if (write !== 1'b0 || read !== 1'b0 || writedata !== 16'h0000) begin n_fail++; $display("FAIL rstw_outputs: got w=%b r=%b d=%h want 0 0 0000", write, read, writedata); end
    n_checks++; if (fifo_count !== 7'd0 || sent_count !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_state: got cnt=%0d sent=%0d busy=%b want 0 0 0", fifo_count, sent_count, busy); end
    repeat (2) @(negedge clk);
    rst = 0;
    wr_wait_cfg = 0;
    clear_logs();
    inject_rdv = 1;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_txready: got %b want 1", tx_ready); end
    repeat (20) @(negedge clk);
    n_checks++; if (wr_cycles != 0 || read_count != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_quiet: got w=%0d r=%0d busy=%b want 0 0 0", wr_cycles, read_count, busy); end
    push(8'h77);
    wait_idle(ok);
    n_checks++; if (!ok || wlog.size() != 1 || wlog[0] !== 16'h0077) begin n_fail++; $display("FAIL rstw_after: got n=%0d want one write of 0077", wlog.size()); end
    n_checks++; if (sent_count !== 8'd1) begin n_fail++; $display("FAIL rstw_sent: got %0d want 1", sent_count); end
  endtask

  task automatic test_tmt();
    bit ok;
    int exp_reads;
`ifdef LED_CUBE_UART_TX_TMT_CHECK_EN
    exp_reads = 2;
`else
    exp_reads = 1;
`endif
    clear_logs();
    status_q = '{16'h0040, 16'h0060};
    push(8'h33);
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmt_timeout: got busy want idle"); end
    n_checks++; if (read_count != exp_reads) begin n_fail++; $display("FAIL tmt_reads: got %0d want %0d", read_count, exp_reads); end
    n_checks++; if (wlog.size() != 1 || wlog[0] !== 16'h0033) begin n_fail++; $display("FAIL tmt_write: got n=%0d want one write of 0033", wlog.size()); end
    n_checks++; if (sent_count !== 8'd2) begin n_fail++; $display("FAIL tmt_sent: got %0d want 2", sent_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_poll_retry();
    test_back_to_back();
    test_waitrequest();
    test_reset_mid_write();
    test_tmt();
    n_checks++; if (both_err != 0 || addr_err != 0 || wd_err != 0) begin n_fail++; $display("FAIL bus_rules: got both=%0d addr=%0d wdata=%0d want 0 0 0", both_err, addr_err, wd_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
